// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports its high time and
// period in clk cycles, with a stuck-input timeout. Lives in the clk domain;
// pwm_in is brought in through a two-flop synchroniser.
module pwm_capture #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             valid,
    output logic             timeout,
    output logic             stuck_level
);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // synchroniser and edge-detect history
    logic s1_r;
    logic s2_r;
    logic prev_r;

    // measurement state
    state_t           state_r;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] high_latch_r;
    logic [CNT_W-1:0] high_latch_n;

    // next values of the registered outputs
    logic [CNT_W-1:0] high_count_n;
    logic [CNT_W-1:0] period_count_n;
    logic             valid_n;
    logic             timeout_n;
    logic             stuck_level_n;

    logic rise_s;
    logic fall_s;
    logic adv_edge_s;
    logic timeout_hit_s;

    assign rise_s = s2_r & ~prev_r;
    assign fall_s = ~s2_r & prev_r;

    // The edge that moves the FSM forward: fall while high, rise otherwise.
    assign adv_edge_s = (state_r == HIGH) ? fall_s : rise_s;

    // An advancing edge on the saturation cycle wins over the timeout.
    assign timeout_hit_s = (cnt_r == CNT_MAX) && !adv_edge_s;

    // Synchronise pwm_in and keep one extra stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            s1_r   <= pwm_in;
            s2_r   <= s1_r;
            prev_r <= s2_r;
        end
    end

    // Cycle counter: restarts at 1 on every rise, saturates at TIMEOUT.
    always_comb begin
        cnt_n = cnt_r;
        if (rise_s) begin
            cnt_n = CNT_ONE;
        end else if (cnt_r == CNT_MAX) begin
            cnt_n = cnt_r;
        end else begin
            cnt_n = cnt_r + CNT_ONE;
        end
    end

    // Next-state and next-output logic for the measurement FSM.
    always_comb begin
        state_n        = state_r;
        high_latch_n   = high_latch_r;
        high_count_n   = high_count;
        period_count_n = period_count;
        valid_n        = 1'b0;
        timeout_n      = timeout;
        stuck_level_n  = stuck_level;

        if (timeout_hit_s) begin
            // Input stuck: drop results, remember the level, resync on next rise.
            state_n        = SYNC;
            timeout_n      = 1'b1;
            stuck_level_n  = s2_r;
            high_count_n   = CNT_ZERO;
            period_count_n = CNT_ZERO;
        end else begin
            case (state_r)
                SYNC: begin
                    // First rise only starts a period; nothing is reported.
                    if (rise_s) begin
                        state_n = HIGH;
                    end else begin
                        state_n = SYNC;
                    end
                end
                HIGH: begin
                    if (fall_s) begin
                        high_latch_n = cnt_r;
                        state_n      = LOW;
                    end else begin
                        state_n = HIGH;
                    end
                end
                LOW: begin
                    // Closing rise: publish the complete period.
                    if (rise_s) begin
                        high_count_n   = high_latch_r;
                        period_count_n = cnt_r;
                        valid_n        = 1'b1;
                        timeout_n      = 1'b0;
                        state_n        = HIGH;
                    end else begin
                        state_n = LOW;
                    end
                end
                default: begin
                    state_n = SYNC;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= SYNC;
            cnt_r        <= CNT_ZERO;
            high_latch_r <= CNT_ZERO;
            high_count   <= CNT_ZERO;
            period_count <= CNT_ZERO;
            valid        <= 1'b0;
            timeout      <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            high_latch_r <= high_latch_n;
            high_count   <= high_count_n;
            period_count <= period_count_n;
            valid        <= valid_n;
            timeout      <= timeout_n;
            stuck_level  <= stuck_level_n;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture with a shortened timeout so every
// scenario fits in a short run. Expected cycle numbers count from the
// posedge right before a pwm_in change (2-flop sync + edge register = +3).
module tb_pwm_capture;

    localparam int CW = 12;
    localparam int TO = 300;

    logic          clk;
    logic          reset;
    logic          pwm_in;
    logic [CW-1:0] high_count;
    logic [CW-1:0] period_count;
    logic          valid;
    logic          timeout;
    logic          stuck_level;

    int errors;
    int checks;
    int cyc;
    int valid_q[$];
    int last_h;
    int last_p;
    int consec;
    logic valid_d;

    pwm_capture #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .pwm_in       (pwm_in),
        .high_count   (high_count),
        .period_count (period_count),
        .valid        (valid),
        .timeout      (timeout),
        .stuck_level  (stuck_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle number = count of rising edges seen
    always @(posedge clk) cyc <= cyc + 1;

    // record every valid strobe and flag back-to-back strobes
    always @(negedge clk) begin
        if (valid) begin
            valid_q.push_back(cyc);
            last_h <= int'(high_count);
            last_p <= int'(period_count);
        end
        if (valid && valid_d) consec <= consec + 1;
        valid_d <= valid;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int h, input int p, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            tick(h);
            pwm_in = 1'b0;
            tick(p - h);
        end
    endtask

    task automatic wait_timeout(output int at);
        at = -1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (timeout) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        pwm_in = 1'b0;
        tick(5);
        checks++; if (high_count !== '0) begin errors++; $display("FAIL rst_high_count: got %0d expected 0", high_count); end
        checks++; if (period_count !== '0) begin errors++; $display("FAIL rst_period_count: got %0d expected 0", period_count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
        checks++; if (stuck_level !== 1'b0) begin errors++; $display("FAIL rst_stuck: got %b expected 0", stuck_level); end
        reset = 1'b0;
        tick(10);
    endtask

    task automatic test_basic;
        int n;
        int c;
        n = valid_q.size();
        c = cyc;
        drive(25, 100, 3);
        checks++; if (valid_q.size() !== n + 2) begin errors++; $display("FAIL basic_nvalid: got %0d expected %0d", valid_q.size() - n, 2); end
        if (valid_q.size() >= n + 2) begin
            checks++; if (valid_q[n] !== c + 103) begin errors++; $display("FAIL basic_first_valid_cyc: got %0d expected %0d", valid_q[n], c + 103); end
            checks++; if (valid_q[n+1] - valid_q[n] !== 100) begin errors++; $display("FAIL basic_spacing: got %0d expected 100", valid_q[n+1] - valid_q[n]); end
        end
        checks++; if (last_h !== 25) begin errors++; $display("FAIL basic_high: got %0d expected 25", last_h); end
        checks++; if (last_p !== 100) begin errors++; $display("FAIL basic_period: got %0d expected 100", last_p); end
    endtask

    task automatic test_duty_sweep;
        int duty[3];
        int n;
        duty[0] = 10;
        duty[1] = 50;
        duty[2] = 90;
        for (int k = 0; k < 3; k++) begin
            n = valid_q.size();
            drive(duty[k], 100, 2);
            checks++; if (valid_q.size() !== n + 2) begin errors++; $display("FAIL duty%0d_nvalid: got %0d expected 2", duty[k], valid_q.size() - n); end
            checks++; if (last_h !== duty[k]) begin errors++; $display("FAIL duty%0d_high: got %0d expected %0d", duty[k], last_h, duty[k]); end
            checks++; if (last_p !== 100) begin errors++; $display("FAIL duty%0d_period: got %0d expected 100", duty[k], last_p); end
        end
    endtask

    task automatic test_timeout_high;
        int n;
        int c;
        int at;
        n = valid_q.size();
        c = cyc;
        pwm_in = 1'b1;
        wait_timeout(at);
        #1;
        checks++; if (at !== c + 3 + TO) begin errors++; $display("FAIL to_high_cycle: got %0d expected %0d", at, c + 3 + TO); end
        checks++; if (stuck_level !== 1'b1) begin errors++; $display("FAIL to_high_stuck: got %b expected 1", stuck_level); end
        checks++; if (high_count !== '0) begin errors++; $display("FAIL to_high_hc: got %0d expected 0", high_count); end
        checks++; if (period_count !== '0) begin errors++; $display("FAIL to_high_pc: got %0d expected 0", period_count); end
        checks++; if (valid_q.size() !== n + 1) begin errors++; $display("FAIL to_high_nvalid: got %0d expected 1", valid_q.size() - n); end
        tick(400);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_high_hold: got %b expected 1", timeout); end
        checks++; if (valid_q.size() !== n + 1) begin errors++; $display("FAIL to_high_hold_nvalid: got %0d expected 1", valid_q.size() - n); end
        checks++; if (stuck_level !== 1'b1) begin errors++; $display("FAIL to_high_hold_stuck: got %b expected 1", stuck_level); end
    endtask

    task automatic test_resume_then_low;
        int n;
        int c;
        int at;
        pwm_in = 1'b0;
        tick(10);
        n = valid_q.size();
        c = cyc;
        pwm_in = 1'b1;
        tick(50);
        pwm_in = 1'b0;
        tick(50);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL resume_partial_timeout: got %b expected 1", timeout); end
        checks++; if (valid_q.size() !== n) begin errors++; $display("FAIL resume_partial_nvalid: got %0d expected 0", valid_q.size() - n); end
        drive(50, 100, 2);
        checks++; if (valid_q.size() !== n + 2) begin errors++; $display("FAIL resume_nvalid: got %0d expected 2", valid_q.size() - n); end
        if (valid_q.size() >= n + 1) begin
            checks++; if (valid_q[n] !== c + 103) begin errors++; $display("FAIL resume_valid_cyc: got %0d expected %0d", valid_q[n], c + 103); end
        end
        checks++; if (last_h !== 50) begin errors++; $display("FAIL resume_high: got %0d expected 50", last_h); end
        checks++; if (last_p !== 100) begin errors++; $display("FAIL resume_period: got %0d expected 100", last_p); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL resume_timeout_clr: got %b expected 0", timeout); end
        wait_timeout(at);
        #1;
        checks++; if (at !== c + 203 + TO) begin errors++; $display("FAIL to_low_cycle: got %0d expected %0d", at, c + 203 + TO); end
        checks++; if (stuck_level !== 1'b0) begin errors++; $display("FAIL to_low_stuck: got %b expected 0", stuck_level); end
        checks++; if (period_count !== '0) begin errors++; $display("FAIL to_low_pc: got %0d expected 0", period_count); end
    endtask

    task automatic test_reset_mid;
        int n;
        int c;
        drive(50, 100, 2);
        checks++; if (int'(high_count) !== 50) begin errors++; $display("FAIL mid_pre_hc: got %0d expected 50", high_count); end
        pwm_in = 1'b1;
        tick(20);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (high_count !== '0) begin errors++; $display("FAIL mid_rst_hc: got %0d expected 0", high_count); end
        checks++; if (period_count !== '0) begin errors++; $display("FAIL mid_rst_pc: got %0d expected 0", period_count); end
        checks++; if (valid !== 1'b0 || timeout !== 1'b0 || stuck_level !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got %b%b%b expected 000", valid, timeout, stuck_level); end
        pwm_in = 1'b0;
        tick(5);
        reset = 1'b0;
        tick(30);
        n = valid_q.size();
        c = cyc;
        drive(50, 100, 2);
        checks++; if (valid_q.size() !== n + 1) begin errors++; $display("FAIL mid_post_nvalid: got %0d expected 1", valid_q.size() - n); end
        if (valid_q.size() >= n + 1) begin
            checks++; if (valid_q[n] !== c + 103) begin errors++; $display("FAIL mid_post_valid_cyc: got %0d expected %0d", valid_q[n], c + 103); end
        end
    endtask

    task automatic test_min_width;
        int n;
        int c;
        n = valid_q.size();
        c = cyc;
        drive(2, 4, 6);
        checks++; if (valid_q.size() !== n + 6) begin errors++; $display("FAIL min_nvalid: got %0d expected 6", valid_q.size() - n); end
        if (valid_q.size() >= n + 6) begin
            checks++; if (valid_q[n+5] !== c + 23) begin errors++; $display("FAIL min_last_cyc: got %0d expected %0d", valid_q[n+5], c + 23); end
            checks++; if (valid_q[n+5] - valid_q[n+4] !== 4) begin errors++; $display("FAIL min_spacing: got %0d expected 4", valid_q[n+5] - valid_q[n+4]); end
        end
        checks++; if (last_h !== 2) begin errors++; $display("FAIL min_high: got %0d expected 2", last_h); end
        checks++; if (last_p !== 4) begin errors++; $display("FAIL min_period: got %0d expected 4", last_p); end
        checks++; if (consec !== 0) begin errors++; $display("FAIL valid_back_to_back: got %0d expected 0", consec); end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        cyc     = 0;
        last_h  = 0;
        last_p  = 0;
        consec  = 0;
        valid_d = 1'b0;
        reset   = 1'b1;
        pwm_in  = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_duty_sweep;
        test_timeout_high;
        test_resume_then_low;
        test_reset_mid;
        test_min_width;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
